// File: rtl/epu_sram_responder_if.sv
// Bus bundle for the EPU SRAM responder: compute-side port, host-side
// request/grant port and the sticky status flags.
interface epu_sram_responder_if;
  logic        cpt_cs;
  logic        cpt_oe;
  logic        cpt_w_req;
  logic [31:0] cpt_addr;
  logic [31:0] cpt_w_data;
  logic [31:0] cpt_r_data;
  logic        hst_req;
  logic        hst_we;
  logic [31:0] hst_addr;
  logic [31:0] hst_wdata;
  logic        hst_gnt;
  logic        hst_rvalid;
  logic [31:0] hst_rdata;
  logic        hst_starve;
  logic        addr_err;

  modport master (
    output cpt_cs, cpt_oe, cpt_w_req, cpt_addr, cpt_w_data,
    output hst_req, hst_we, hst_addr, hst_wdata,
    input  cpt_r_data, hst_gnt, hst_rvalid, hst_rdata, hst_starve, addr_err
  );

  modport slave (
    input  cpt_cs, cpt_oe, cpt_w_req, cpt_addr, cpt_w_data,
    input  hst_req, hst_we, hst_addr, hst_wdata,
    output cpt_r_data, hst_gnt, hst_rvalid, hst_rdata, hst_starve, addr_err
  );
endinterface

// File: rtl/epu_sram_responder.sv
// Single-port word SRAM shared by a stall-free compute port and a
// request/grant host port that only gets cycles the compute side leaves idle.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

module epu_sram_responder #(
  parameter int DEPTH      = 1024,
  parameter int STARVE_LIM = 16
) (
  input logic                   clk,
  input logic                   rstn,
  epu_sram_responder_if.slave   bus
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(STARVE_LIM + 1);
  localparam logic [31:0]     DEPTH_W = 32'(DEPTH);
  localparam logic [CW-1:0]   LIM_C   = CW'(STARVE_LIM);

  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_RESP} hst_state_t;

  hst_state_t    state_reg;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   cpt_rd_reg;
  logic [31:0]   hst_rdata_reg;
  logic [CW-1:0] blk_cnt_reg;
  logic          starve_reg;
  logic          addr_err_reg;

  logic          cpt_ok, hst_ok;
  logic          cpt_wr, cpt_rd;
  logic          hst_grant, hst_wr, hst_rd, hst_blocked;
  logic [AW-1:0] cpt_idx, hst_idx;

  assign cpt_ok  = bus.cpt_addr < DEPTH_W;
  assign hst_ok  = bus.hst_addr < DEPTH_W;
  assign cpt_idx = bus.cpt_addr[AW-1:0];
  assign hst_idx = bus.hst_addr[AW-1:0];

  assign cpt_wr = bus.cpt_cs && (bus.cpt_w_req == `WRITE_ENB);
  assign cpt_rd = bus.cpt_cs && (bus.cpt_w_req == `WRITE_DIS);

  // The host is granted in any state whenever compute leaves the array idle,
  // so H_WAIT and H_RESP both re-evaluate a pending request like H_IDLE.
  assign hst_grant   = rstn && bus.hst_req && !bus.cpt_cs;
  assign hst_wr      = hst_grant && bus.hst_we;
  assign hst_rd      = hst_grant && !bus.hst_we;
  assign hst_blocked = bus.hst_req && bus.cpt_cs;

  // Array has no reset so contents survive rstn; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (cpt_wr && cpt_ok)
        mem[cpt_idx] <= bus.cpt_w_data;
      else if (hst_wr && hst_ok)
        mem[hst_idx] <= bus.hst_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= H_IDLE;
      cpt_rd_reg    <= '0;
      hst_rdata_reg <= '0;
      blk_cnt_reg   <= '0;
      starve_reg    <= 1'b0;
      addr_err_reg  <= 1'b0;
    end else begin
      if (cpt_rd)
        cpt_rd_reg <= cpt_ok ? mem[cpt_idx] : 32'h0;
      if (hst_rd)
        hst_rdata_reg <= hst_ok ? mem[hst_idx] : 32'h0;

      if ((bus.cpt_cs && !cpt_ok) || (hst_grant && !hst_ok))
        addr_err_reg <= 1'b1;

      // Saturating run-length of denied host cycles; the flag is sticky.
      if (hst_blocked) begin
        if (blk_cnt_reg != LIM_C)
          blk_cnt_reg <= blk_cnt_reg + CW'(1);
        if (blk_cnt_reg >= LIM_C - CW'(1))
          starve_reg <= 1'b1;
      end else begin
        blk_cnt_reg <= '0;
      end

      case (state_reg)
        H_IDLE, H_WAIT, H_RESP: begin
          if (hst_grant)
            state_reg <= bus.hst_we ? H_IDLE : H_RESP;
          else if (bus.hst_req)
            state_reg <= H_WAIT;
          else
            state_reg <= H_IDLE;
        end
        default: state_reg <= H_IDLE;
      endcase
    end
  end

  assign bus.cpt_r_data = bus.cpt_oe ? cpt_rd_reg : 32'h0;
  assign bus.hst_gnt    = hst_grant;
  assign bus.hst_rvalid = (state_reg == H_RESP);
  assign bus.hst_rdata  = hst_rdata_reg;
  assign bus.hst_starve = starve_reg;
  assign bus.addr_err   = addr_err_reg;

endmodule

// File: tb/tb_epu_sram_responder.sv
// Directed bench for epu_sram_responder: host reads are scoreboarded through
// a queue, compute reads and flags through a small behavioural memory model.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

module tb_epu_sram_responder;
  localparam int DEPTH      = 1024;
  localparam int STARVE_LIM = 16;

  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;

  epu_sram_responder_if bus ();

  epu_sram_responder #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [logic [31:0]];
  logic [31:0] hq [$];
  logic [31:0] cpt_model;
  logic        err_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a >= 32'(DEPTH)) return 32'h0;
    if (model.exists(a)) return model[a];
    return 'x;
  endfunction

  // One clock: predict grant/access from the inputs, advance, then check.
  task automatic tick();
    logic g, rd;
    #1;
    g  = rstn && bus.hst_req && !bus.cpt_cs;
    rd = g && !bus.hst_we;
    chk("hst_gnt", {31'b0, bus.hst_gnt}, {31'b0, g});
    if (rd) hq.push_back(mread(bus.hst_addr));
    if (g && bus.hst_we && bus.hst_addr < 32'(DEPTH)) model[bus.hst_addr] = bus.hst_wdata;
    if (g && bus.hst_addr >= 32'(DEPTH)) err_model = 1'b1;
    if (bus.cpt_cs) begin
      if (bus.cpt_addr >= 32'(DEPTH)) err_model = 1'b1;
      if (bus.cpt_w_req == `WRITE_ENB) begin
        if (bus.cpt_addr < 32'(DEPTH)) model[bus.cpt_addr] = bus.cpt_w_data;
      end else begin
        cpt_model = mread(bus.cpt_addr);
      end
    end
    if (g) $display("[TB] t=%0t host %s addr=%h", $time, bus.hst_we ? "write" : "read", bus.hst_addr);
    @(posedge clk);
    #1;
    chk("hst_rvalid", {31'b0, bus.hst_rvalid}, {31'b0, rd});
    if (bus.hst_rvalid && hq.size() > 0) begin
      logic [31:0] e;
      e = hq.pop_front();
      chk("hst_rdata", bus.hst_rdata, e);
      $display("[TB] t=%0t host rvalid rdata=%h", $time, bus.hst_rdata);
    end
    chk("cpt_r_data", bus.cpt_r_data, bus.cpt_oe ? cpt_model : 32'h0);
    chk("addr_err", {31'b0, bus.addr_err}, {31'b0, err_model});
  endtask

  task automatic host(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.hst_req = req; bus.hst_we = we; bus.hst_addr = a; bus.hst_wdata = d;
  endtask

  task automatic cpt(input logic cs, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.cpt_cs = cs; bus.cpt_w_req = wr ? `WRITE_ENB : `WRITE_DIS;
    bus.cpt_addr = a; bus.cpt_w_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    cpt_model = 32'h0; err_model = 1'b0;
    rstn = 1'b0;
    bus.cpt_oe = 1'b0;
    cpt(0, 0, 0, 0);
    host(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.cpt_oe = 1'b1;
    #1;
    chk("rst_cpt_r_data", bus.cpt_r_data, 32'h0);
    chk("rst_hst_gnt", {31'b0, bus.hst_gnt}, 32'h0);
    chk("rst_hst_rvalid", {31'b0, bus.hst_rvalid}, 32'h0);
    chk("rst_hst_rdata", bus.hst_rdata, 32'h0);
    chk("rst_hst_starve", {31'b0, bus.hst_starve}, 32'h0);
    chk("rst_addr_err", {31'b0, bus.addr_err}, 32'h0);
    rstn = 1'b1;

    // Compute write then read-back with oe on and off.
    cpt(1, 1, 5, 32'h1234_5678); tick();
    cpt(1, 0, 5, 0);             tick();
    chk("cpt_read_5", bus.cpt_r_data, 32'h1234_5678);
    cpt(0, 0, 0, 0); bus.cpt_oe = 1'b0; tick();
    bus.cpt_oe = 1'b1;

    // Host write then read with compute idle.
    host(1, 1, 7, 32'hA5A5_0001); tick();
    host(1, 0, 7, 0);             tick();
    host(0, 0, 0, 0);             tick();
    chk("hst_rdata_hold", bus.hst_rdata, 32'hA5A5_0001);

    // Host read blocked four cycles by compute reads.
    host(1, 1, 3, 32'h0000_3333); tick();
    host(1, 0, 3, 0);
    cpt(1, 0, 5, 0);
    repeat (4) tick();
    cpt(0, 0, 0, 0); tick();
    host(0, 0, 0, 0); tick();
    chk("starve_after_4", {31'b0, bus.hst_starve}, 32'h0);

    // Back-to-back host reads.
    host(1, 0, 5, 0); tick();
    host(1, 0, 7, 0); tick();
    host(0, 0, 0, 0); tick();

    // Blocked host write abandoned in H_WAIT must not touch memory.
    host(1, 1, 9, 32'h0000_0099); tick();
    cpt(1, 0, 7, 0);
    host(1, 1, 9, 32'hDEAD_BEEF); tick();
    cpt(0, 0, 0, 0);
    host(0, 0, 0, 0); tick();
    host(1, 0, 9, 0); tick();
    host(0, 0, 0, 0); tick();

    // Starvation: 20 blocked cycles, flag after the 16th, sticky after grant.
    cpt(1, 0, 5, 0);
    host(1, 0, 7, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == STARVE_LIM - 1) chk("starve_before_lim", {31'b0, bus.hst_starve}, 32'h0);
      if (i == STARVE_LIM)     chk("starve_at_lim", {31'b0, bus.hst_starve}, 32'h1);
    end
    cpt(0, 0, 0, 0); tick();
    host(0, 0, 0, 0); tick();
    chk("starve_sticky", {31'b0, bus.hst_starve}, 32'h1);

    // Out-of-range accesses.
    host(1, 1, 2, 32'h0000_2222); tick();
    host(0, 0, 0, 0);
    cpt(1, 0, 32'(DEPTH), 0); tick();
    chk("cpt_oob_read", bus.cpt_r_data, 32'h0);
    chk("addr_err_set", {31'b0, bus.addr_err}, 32'h1);
    cpt(0, 0, 0, 0);
    host(1, 1, 32'(DEPTH + 2), 32'h0BAD_0BAD); tick();
    host(1, 0, 32'(DEPTH + 2), 0); tick();
    host(1, 0, 2, 0); tick();
    host(0, 0, 0, 0); tick();

    // Reset while in H_RESP drops the response; memory survives.
    host(1, 0, 7, 0);
    #1;
    chk("gnt_before_reset", {31'b0, bus.hst_gnt}, 32'h1);
    @(posedge clk);
    rstn = 1'b0;
    host(0, 0, 0, 0);
    #1;
    chk("rst_mid_rvalid", {31'b0, bus.hst_rvalid}, 32'h0);
    chk("rst_mid_rdata", bus.hst_rdata, 32'h0);
    chk("rst_mid_gnt", {31'b0, bus.hst_gnt}, 32'h0);
    chk("rst_mid_starve", {31'b0, bus.hst_starve}, 32'h0);
    chk("rst_mid_addr_err", {31'b0, bus.addr_err}, 32'h0);
    chk("rst_mid_cpt_r_data", bus.cpt_r_data, 32'h0);
    hq.delete();
    cpt_model = 32'h0;
    err_model = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    cpt(1, 0, 5, 0); tick();
    chk("mem_retained_5", bus.cpt_r_data, 32'h1234_5678);
    cpt(0, 0, 0, 0); tick();
    chk("hq_drained", 32'(hq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
